// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with divider handshake and stall counter
// Optional divider watchdog enabled by defining PIPE_CTRL_WDT_EN.
module pipe_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq,
  input  logic        ex_stallreq,
  input  logic        div_req,
  input  logic        div_ready,
  input  logic        flush_req,
  input  logic [31:0] exc_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, DIV_RUN = 1'b1} state_t;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [15:0] WDT_LAST   = 16'(DIV_TIMEOUT - 1);

  state_t state, state_nxt;
  logic   wdt_fire;

`ifdef PIPE_CTRL_WDT_EN
  logic [15:0] wdt_cnt;
  logic        div_timeout_q;

  // Counter is zero in the first DIV_RUN cycle because it is held clear outside DIV_RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt       <= '0;
      div_timeout_q <= 1'b0;
    end else begin
      if (state == DIV_RUN) wdt_cnt <= wdt_cnt + 16'd1;
      else                  wdt_cnt <= '0;
      if (wdt_fire) div_timeout_q <= 1'b1;
    end
  end

  assign wdt_fire    = !rst && (state == DIV_RUN) && (wdt_cnt == WDT_LAST)
                       && !div_ready && !flush_req;
  assign div_timeout = div_timeout_q;
`else
  wire unused_wdt_last = ^WDT_LAST;
  assign wdt_fire    = 1'b0;
  assign div_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rst || flush_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (div_req) state_nxt = DIV_RUN;
        DIV_RUN: if (div_ready || wdt_fire) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The instruction stays held in EX during the watchdog cancel cycle; it relaunches next cycle.
  always_comb begin
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = 32'h0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    if (rst) begin
      stall = STALL_NONE;
    end else if (flush_req) begin
      flush      = 1'b1;
      new_pc     = exc_pc;
      div_cancel = (state == DIV_RUN);
    end else if (state == IDLE && div_req) begin
      div_start = 1'b1;
      stall     = STALL_EX;
    end else if (state == DIV_RUN) begin
      if (wdt_fire) begin
        div_cancel = 1'b1;
        stall      = STALL_EX;
      end else if (!div_ready) begin
        stall = STALL_EX;
      end
    end else if (ex_stallreq) begin
      stall = STALL_EX;
    end else if (id_stallreq) begin
      stall = STALL_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           stall_cnt <= 32'h0;
    else if (stall[0]) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
// Watchdog expectations follow PIPE_CTRL_WDT_EN with DIV_TIMEOUT=8.
module tb_pipe_ctrl;

  localparam logic [5:0] S0 = 6'h00;
  localparam logic [5:0] S7 = 6'h07;
  localparam logic [5:0] SF = 6'h0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stallreq = 1'b1, ex_stallreq = 1'b1, div_req = 1'b1;
  logic        div_ready = 1'b1, flush_req = 1'b1;
  logic [31:0] exc_pc = 32'hFFFF_FFFF;
  logic [5:0]  stall;
  logic        flush, div_start, div_cancel, div_timeout;
  logic [31:0] new_pc, stall_cnt;

  pipe_ctrl #(.DIV_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_stallreq(ex_stallreq),
    .div_req(div_req), .div_ready(div_ready), .flush_req(flush_req), .exc_pc(exc_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .div_start(div_start),
    .div_cancel(div_cancel), .div_timeout(div_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        start;
    logic        cancel;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 32'h0;
  logic        exp_to = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic id, input logic ex,
                      input logic dq, input logic dr, input logic fq, input logic [31:0] pc,
                      input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                      input logic e_start, input logic e_cancel);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = r; id_stallreq = id; ex_stallreq = ex; div_req = dq;
    div_ready = dr; flush_req = fq; exc_pc = pc;
    e.stall = e_stall; e.flush = e_flush; e.new_pc = e_pc; e.start = e_start;
    e.cancel = e_cancel; e.to = exp_to; e.cnt = exp_cnt;
    exp_q.push_back(e);
    #2;
    g = exp_q.pop_front();
    chk({tag, ".stall"},       32'(stall),       32'(g.stall));
    chk({tag, ".flush"},       32'(flush),       32'(g.flush));
    chk({tag, ".new_pc"},      new_pc,           g.new_pc);
    chk({tag, ".div_start"},   32'(div_start),   32'(g.start));
    chk({tag, ".div_cancel"},  32'(div_cancel),  32'(g.cancel));
    chk({tag, ".div_timeout"}, 32'(div_timeout), 32'(g.to));
    chk({tag, ".stall_cnt"},   stall_cnt,        g.cnt);
    if (r) begin
      exp_cnt = 32'h0;
      exp_to  = 1'b0;
    end else begin
      if (g.stall[0]) exp_cnt = exp_cnt + 32'd1;
      if (g.cancel && !g.flush) exp_to = 1'b1;
    end
  endtask

  initial begin
    // reset with every request active
    step("rst1",     1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, S0, 0, 0, 0, 0);
    step("rst2",     1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, S0, 0, 0, 0, 0);
    step("rel_id",   0, 1, 0, 0, 0, 0, 32'h0, S7, 0, 0, 0, 0);
    step("id_ex",    0, 1, 1, 0, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("id_only",  0, 1, 0, 0, 0, 0, 32'h0, S7, 0, 0, 0, 0);
    step("quiet1",   0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 0, 0, 0);
    step("rdy_idle", 0, 0, 0, 0, 1, 0, 32'h0, S0, 0, 0, 0, 0);

    // four-cycle divide, then back-to-back next divide
    step("div_a",    0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 1, 0);
    step("div_b",    0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("div_c",    0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("div_d",    0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("div_e",    0, 0, 0, 1, 1, 0, 32'h0, S0, 0, 0, 0, 0);
    step("div_f",    0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 1, 0);
    step("div_g",    0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("div_fl",   0, 0, 0, 1, 0, 1, 32'h0000_0180, S0, 1, 32'h180, 0, 1);
    step("post_fl",  0, 1, 0, 0, 0, 0, 32'h0, S7, 0, 0, 0, 0);
    step("idle_fl",  0, 0, 0, 1, 0, 1, 32'h0000_0200, S0, 1, 32'h200, 0, 0);
    step("quiet2",   0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 0, 0, 0);

    // divider never answers
    step("wd_start", 0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++)
      step($sformatf("wd_run%0d", i), 0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
`ifdef PIPE_CTRL_WDT_EN
    step("wd_fire",  0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 1);
    step("wd_relau", 0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 1, 0);
    step("wd_run",   0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
`else
    for (int i = 8; i <= 10; i++)
      step($sformatf("wd_wait%0d", i), 0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
`endif
    step("wd_done",  0, 0, 0, 1, 1, 0, 32'h0, S0, 0, 0, 0, 0);
    step("quiet3",   0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 0, 0, 0);

    // counter wrap from a preloaded value
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    exp_cnt = 32'hFFFF_FFFE;
    step("wrap0",    0, 0, 1, 0, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("wrap1",    0, 0, 1, 0, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("wrap2",    0, 0, 1, 0, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("wrap_end", 0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 0, 0, 0);
    chk("wrap_val", stall_cnt, 32'h1);

    // reset in the middle of a division: no cancel, back to IDLE
    step("md_start", 0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 1, 0);
    step("md_run",   0, 0, 0, 1, 0, 0, 32'h0, SF, 0, 0, 0, 0);
    step("md_rst",   1, 1, 1, 1, 0, 0, 32'h0, S0, 0, 0, 0, 0);
    step("md_after", 0, 1, 0, 0, 0, 0, 32'h0, S7, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
